// File: rtl/ft_sync_pkg.sv
// rtl/ft_sync_pkg.sv - shared types and byte-lane helper for the FT245 sync deframer
package ft_sync_pkg;

  typedef enum logic [1:0] {HUNT, CMD, ADDR, DATA} state_t;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] SYNC_DEFAULT = 8'hCD;

  // Shifts one byte into an nbytes-wide field; after nbytes calls the first byte sits at
  // the MSB (big) or LSB (little). Callers truncate the result to the field width.
  function automatic logic [127:0] lane_shift(input logic [127:0] acc, input logic [7:0] b,
                                              input int nbytes, input logic big);
    logic [127:0] wide;
    wide = {120'd0, b};
    if (big) lane_shift = (acc << 8) | wide;
    else     lane_shift = (acc >> 8) | (wide << (8 * (nbytes - 1)));
  endfunction

endpackage

// File: rtl/hi_word_fifo.sv
// rtl/hi_word_fifo.sv - synchronous word FIFO between the deframer and the host master
module hi_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal when the same cycle pops.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/ft_sync_deframer.sv
// rtl/ft_sync_deframer.sv - parses 0xCD-synced {command, address, data} frames from the
// FT245 receive byte stream into buffered host-interface words
module ft_sync_deframer
  import ft_sync_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         BIG_ENDIAN = 1,
  parameter int         FIFO_DEPTH = 16,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  master_ready,
  output logic                  ih_ready,
  output logic [31:0]           in_command,
  output logic [31:0]           in_address,
  output logic [27:0]           in_data_count,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int         BYTES   = DATA_WIDTH / 8;
  localparam logic [3:0] LAST_DB = 4'(BYTES - 1);
  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;

  state_t                state, next_state;
  logic [3:0]            byte_cnt;
  logic [23:0]           word_cnt, words_expected;
  logic [31:0]           hdr_acc, hdr_next, to_cnt;
  logic [DATA_WIDTH-1:0] data_acc, data_next, fifo_data;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  ready_c, accept, push, pop, to_hit, hdr_last;

  assign hdr_next  = 32'(lane_shift(128'(hdr_acc), byte_in, 4, BIG_ENDIAN != 0));
  assign data_next = DATA_WIDTH'(lane_shift(128'(data_acc), byte_in, BYTES, BIG_ENDIAN != 0));
  assign hdr_last  = (byte_cnt == 4'd3);
  assign words_expected = (in_command[31:24] != OP_WRITE) ? 24'd1 :
                          (in_command[23:0] == 24'd0) ? 24'd1 : in_command[23:0];

  // Header latches wait for the FIFO to drain so in_command/in_address stay valid
  // for every word of the previous frame.
  always_comb begin
    ready_c = 1'b0;
    case (state)
      HUNT:     ready_c = 1'b1;
      CMD:      ready_c = !(hdr_last && !fifo_empty);
      ADDR:     ready_c = !(hdr_last && !fifo_empty);
      DATA:     ready_c = !fifo_full || pop;
      default:  ready_c = 1'b0;
    endcase
  end

  assign byte_ready = ready_c && !rst;
  assign accept     = byte_valid && byte_ready;
  assign pop        = !fifo_empty && master_ready;
  assign push       = accept && (state == DATA) && (byte_cnt == LAST_DB);
  assign to_hit     = (TIMEOUT != 0) && (state != HUNT) && !byte_valid &&
                      (to_cnt == 32'(TIMEOUT - 1));
  assign busy       = (state != HUNT) || (fifo_count != '0);

  always_comb begin
    next_state = state;
    case (state)
      HUNT: if (accept && byte_in == SYNC_BYTE) next_state = CMD;
      CMD:  if (accept && hdr_last) next_state = ADDR;
      ADDR: if (accept && hdr_last) next_state = DATA;
      DATA: if (accept && byte_cnt == LAST_DB && word_cnt == 24'd1) next_state = HUNT;
      default: next_state = HUNT;
    endcase
    if (to_hit) next_state = HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt      <= '0;
      word_cnt      <= '0;
      hdr_acc       <= '0;
      data_acc      <= '0;
      to_cnt        <= '0;
      ih_ready      <= 1'b0;
      in_data       <= '0;
      in_command    <= '0;
      in_address    <= '0;
      in_data_count <= '0;
      frame_error   <= 1'b0;
    end else begin
      frame_error <= to_hit;
      ih_ready    <= pop;
      if (pop) in_data <= fifo_data;

      if (accept || state == HUNT || to_hit) to_cnt <= '0;
      else if (!byte_valid)                  to_cnt <= to_cnt + 32'd1;

      if (to_hit) begin
        byte_cnt <= '0;
      end else if (accept) begin
        case (state)
          HUNT: byte_cnt <= '0;
          CMD: begin
            hdr_acc  <= hdr_next;
            byte_cnt <= hdr_last ? 4'd0 : byte_cnt + 4'd1;
            if (hdr_last) begin
              in_command    <= hdr_next;
              in_data_count <= (hdr_next[31:24] == OP_WRITE && hdr_next[23:0] == 24'd0) ?
                               28'd1 : {4'd0, hdr_next[23:0]};
            end
          end
          ADDR: begin
            hdr_acc  <= hdr_next;
            byte_cnt <= hdr_last ? 4'd0 : byte_cnt + 4'd1;
            if (hdr_last) begin
              in_address <= hdr_next;
              word_cnt   <= words_expected;
            end
          end
          DATA: begin
            data_acc <= data_next;
            if (byte_cnt == LAST_DB) begin
              byte_cnt <= '0;
              word_cnt <= word_cnt - 24'd1;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          default: byte_cnt <= '0;
        endcase
      end
    end
  end

  hi_word_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_next),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
